// File: rtl/spin_ctrl.sv
// spin_ctrl: slot-machine spin controller.
// Detects rising edges on the debounced spin/coin levels, keeps the credit
// balance, runs the three reels through a staggered spin/stop sequence, then
// scores the stopped symbols and pays out on three-of-a-kind.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   db_spin      debounced spin button level
//   db_coin      debounced coin button level
//   reel0..2     current reel symbols (0-7)
//   reel_moving  bit i high while reel i is advancing
//   busy         high whenever the controller is not idle
//   credits      credit balance (saturates at 255)
//   win          one-cycle pulse on three-of-a-kind
//   win_sym      symbol of the most recent win
module spin_ctrl #(
  parameter int unsigned REEL_DIV     = 1000000,
  parameter int unsigned SPIN_TICKS   = 20,
  parameter int unsigned STOP_GAP     = 10,
  parameter bit          RAND_EN      = 1'b1,
  parameter int unsigned INIT_CREDITS = 10,
  parameter int unsigned PAYOUT       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       db_spin,
  input  logic       db_coin,
  output logic [2:0] reel0,
  output logic [2:0] reel1,
  output logic [2:0] reel2,
  output logic [2:0] reel_moving,
  output logic       busy,
  output logic [7:0] credits,
  output logic       win,
  output logic [2:0] win_sym
);

  localparam int unsigned DIV_W  = $clog2(REEL_DIV);
  localparam int unsigned TL_MAX = (SPIN_TICKS + 7 > STOP_GAP) ? SPIN_TICKS + 7 : STOP_GAP;
  localparam int unsigned TL_W   = $clog2(TL_MAX + 1);

  typedef enum logic [2:0] {IDLE, SPIN3, SPIN2, SPIN1, SCORE} state_t;

  state_t            state;
  logic              spin_prev;
  logic              coin_prev;
  logic [DIV_W-1:0]  tick_cnt;
  logic [15:0]       lfsr;
  logic [TL_W-1:0]   tick_left;

  logic              start_edge;
  logic              coin_edge;
  logic              tick;
  logic              accept;
  logic              match;
  logic              payout_now;
  logic [TL_W-1:0]   spin_len;
  logic [9:0]        credit_sum;
  logic [7:0]        credit_next;

  always_comb begin
    start_edge  = db_spin & ~spin_prev;
    coin_edge   = db_coin & ~coin_prev;
    tick        = (tick_cnt == DIV_W'(REEL_DIV - 1));
    accept      = (state == IDLE) && start_edge && (credits != '0);
    match       = (reel0 == reel1) && (reel1 == reel2);
    payout_now  = (state == SCORE) && match;
    spin_len    = TL_W'(SPIN_TICKS) + (RAND_EN ? TL_W'(lfsr[2:0]) : '0);
    // All credit events of a cycle are summed together; a start is only
    // accepted with credits != 0, so the sum never goes below zero.
    credit_sum  = {2'b00, credits} + {9'd0, coin_edge}
                + (payout_now ? 10'(PAYOUT) : '0) - {9'd0, accept};
    credit_next = (credit_sum > 10'd255) ? 8'hFF : credit_sum[7:0];
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      spin_prev   <= 1'b1;
      coin_prev   <= 1'b1;
      tick_cnt    <= '0;
      lfsr        <= 16'hACE1;
      tick_left   <= '0;
      reel0       <= '0;
      reel1       <= '0;
      reel2       <= '0;
      reel_moving <= '0;
      credits     <= 8'(INIT_CREDITS);
      win         <= 1'b0;
      win_sym     <= '0;
    end else begin
      spin_prev <= db_spin;
      coin_prev <= db_coin;
      tick_cnt  <= tick ? '0 : tick_cnt + DIV_W'(1);
      // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
      lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      credits   <= credit_next;
      win       <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            state       <= SPIN3;
            reel_moving <= 3'b111;
            tick_left   <= spin_len;
          end
        end
        SPIN3, SPIN2, SPIN1: begin
          if (tick) begin
            if (tick_left != '0) begin
              tick_left <= tick_left - TL_W'(1);
              if (reel_moving[0]) reel0 <= reel0 + 3'd1;
              if (reel_moving[1]) reel1 <= reel1 + 3'd2;
              if (reel_moving[2]) reel2 <= reel2 + 3'd3;
            end else begin
              tick_left   <= TL_W'(STOP_GAP);
              // Clear the lowest set bit: stops the lowest-index moving reel.
              reel_moving <= reel_moving & (reel_moving - 3'd1);
              case (state)
                SPIN3:   state <= SPIN2;
                SPIN2:   state <= SPIN1;
                default: state <= SCORE;
              endcase
            end
          end
        end
        SCORE: begin
          if (match) begin
            win     <= 1'b1;
            win_sym <= reel0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spin_ctrl.sv
// Self-checking bench for spin_ctrl. Three instances with small tick dividers:
//   [0] SPIN_TICKS=8, STOP_GAP=8  (all reels land on 0 -> win)
//   [1] SPIN_TICKS=1, STOP_GAP=1  (reels land on 1,4,1 -> no win)
//   [2] as [1] but INIT_CREDITS=0
// Expected end-of-spin results come from a reel/credit model and are queued
// when a spin is started, then popped when the DUT drops busy.
module tb_spin_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] spin_i;
  logic [2:0] coin_i;
  logic [2:0] r0_o  [3];
  logic [2:0] r1_o  [3];
  logic [2:0] r2_o  [3];
  logic [2:0] mov_o [3];
  logic [2:0] wsym_o[3];
  logic [7:0] cred_o[3];
  logic       busy_o[3];
  logic       win_o [3];

  spin_ctrl #(.REEL_DIV(4), .SPIN_TICKS(8), .STOP_GAP(8), .RAND_EN(1'b0),
              .INIT_CREDITS(10), .PAYOUT(8)) dut_a (
    .clk(clk), .rst(rst), .db_spin(spin_i[0]), .db_coin(coin_i[0]),
    .reel0(r0_o[0]), .reel1(r1_o[0]), .reel2(r2_o[0]), .reel_moving(mov_o[0]),
    .busy(busy_o[0]), .credits(cred_o[0]), .win(win_o[0]), .win_sym(wsym_o[0]));

  spin_ctrl #(.REEL_DIV(4), .SPIN_TICKS(1), .STOP_GAP(1), .RAND_EN(1'b0),
              .INIT_CREDITS(10), .PAYOUT(8)) dut_b (
    .clk(clk), .rst(rst), .db_spin(spin_i[1]), .db_coin(coin_i[1]),
    .reel0(r0_o[1]), .reel1(r1_o[1]), .reel2(r2_o[1]), .reel_moving(mov_o[1]),
    .busy(busy_o[1]), .credits(cred_o[1]), .win(win_o[1]), .win_sym(wsym_o[1]));

  spin_ctrl #(.REEL_DIV(4), .SPIN_TICKS(1), .STOP_GAP(1), .RAND_EN(1'b0),
              .INIT_CREDITS(0), .PAYOUT(8)) dut_c (
    .clk(clk), .rst(rst), .db_spin(spin_i[2]), .db_coin(coin_i[2]),
    .reel0(r0_o[2]), .reel1(r1_o[2]), .reel2(r2_o[2]), .reel_moving(mov_o[2]),
    .busy(busy_o[2]), .credits(cred_o[2]), .win(win_o[2]), .win_sym(wsym_o[2]));

  typedef struct {
    logic [2:0] r0;
    logic [2:0] r1;
    logic [2:0] r2;
    logic       w;
    logic [2:0] ws;
    logic [7:0] cr;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  int spt  [3] = '{8, 1, 1};
  int gap  [3] = '{8, 1, 1};
  int mr0  [3];
  int mr1  [3];
  int mr2  [3];
  int mws  [3];
  int mcred[3];
  int win_cnt[3];

  // Count win pulses; sampled at posedge so the value seen is the one held
  // during the preceding cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) if (win_o[i] === 1'b1) win_cnt[i]++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mcred = '{10, 10, 0};
    mr0 = '{0, 0, 0};
    mr1 = '{0, 0, 0};
    mr2 = '{0, 0, 0};
    mws = '{0, 0, 0};
  endtask

  task automatic press_spin(input int d);
    spin_i[d] = 1'b1;
    @(negedge clk);
    spin_i[d] = 1'b0;
  endtask

  task automatic press_coin(input int d);
    coin_i[d] = 1'b1;
    @(negedge clk);
    coin_i[d] = 1'b0;
  endtask

  // Queue the expected outcome of a spin just started on instance d.
  task automatic expect_spin(input int d, input int extra);
    exp_t e;
    int l, g, c;
    l = spt[d];
    g = gap[d];
    mr0[d] = (mr0[d] + l) % 8;
    mr1[d] = (mr1[d] + 2 * (l + g)) % 8;
    mr2[d] = (mr2[d] + 3 * (l + 2 * g)) % 8;
    e.r0 = 3'(mr0[d]);
    e.r1 = 3'(mr1[d]);
    e.r2 = 3'(mr2[d]);
    e.w  = (mr0[d] == mr1[d]) && (mr1[d] == mr2[d]);
    if (e.w) mws[d] = mr0[d];
    c = mcred[d] + extra + (e.w ? 8 : 0);
    if (c > 255) c = 255;
    mcred[d] = c;
    e.ws = 3'(mws[d]);
    e.cr = 8'(c);
    sb.push_back(e);
  endtask

  // Wait (bounded) for busy to fall, then compare against the queued result.
  task automatic finish_spin(input int d);
    exp_t e;
    int n;
    n = 0;
    while (busy_o[d] !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("spin_done", {31'd0, busy_o[d]}, 32'd0);
    check("sb_pending", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("reel0",   {29'd0, r0_o[d]},   {29'd0, e.r0});
      check("reel1",   {29'd0, r1_o[d]},   {29'd0, e.r1});
      check("reel2",   {29'd0, r2_o[d]},   {29'd0, e.r2});
      check("moving",  {29'd0, mov_o[d]},  32'd0);
      check("win",     {31'd0, win_o[d]},  {31'd0, e.w});
      check("win_sym", {29'd0, wsym_o[d]}, {29'd0, e.ws});
      check("credits", {24'd0, cred_o[d]}, {24'd0, e.cr});
    end
    @(negedge clk);
    check("win_one_cycle", {31'd0, win_o[d]}, 32'd0);
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    spin_i = '0;
    coin_i = '0;
    spin_i[0] = 1'b1;
    win_cnt = '{0, 0, 0};
    model_reset();
    repeat (3) @(negedge clk);

    check("rst_busy",    {31'd0, busy_o[0]}, 32'd0);
    check("rst_credits", {24'd0, cred_o[0]}, 32'd10);
    check("rst_reel0",   {29'd0, r0_o[0]},   32'd0);
    check("rst_reel1",   {29'd0, r1_o[0]},   32'd0);
    check("rst_reel2",   {29'd0, r2_o[0]},   32'd0);
    check("rst_moving",  {29'd0, mov_o[0]},  32'd0);
    check("rst_win",     {31'd0, win_o[0]},  32'd0);
    check("rst_win_sym", {29'd0, wsym_o[0]}, 32'd0);
    check("rst_credits_c", {24'd0, cred_o[2]}, 32'd0);

    // Spin held through reset and beyond must not start a spin.
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("held_busy",    {31'd0, busy_o[0]}, 32'd0);
    check("held_credits", {24'd0, cred_o[0]}, 32'd10);
    spin_i[0] = 1'b0;
    @(negedge clk);

    // Winning spin on instance 0.
    win_cnt[0] = 0;
    press_spin(0);
    mcred[0]--;
    check("start_busy",    {31'd0, busy_o[0]}, 32'd1);
    check("start_credits", {24'd0, cred_o[0]}, 32'd9);
    check("start_moving",  {29'd0, mov_o[0]},  32'd7);
    expect_spin(0, 0);
    finish_spin(0);
    check("win_count_a", win_cnt[0], 32'd1);

    // Zero credits: spin ignored until a coin arrives.
    press_spin(2);
    check("nocred_busy",    {31'd0, busy_o[2]}, 32'd0);
    check("nocred_credits", {24'd0, cred_o[2]}, 32'd0);
    press_coin(2);
    mcred[2]++;
    check("coin_credits", {24'd0, cred_o[2]}, 32'd1);
    @(negedge clk);
    press_spin(2);
    mcred[2]--;
    check("c_start_busy",    {31'd0, busy_o[2]}, 32'd1);
    check("c_start_credits", {24'd0, cred_o[2]}, 32'd0);
    expect_spin(2, 0);
    finish_spin(2);

    // Non-winning spin with extra presses during the spin.
    win_cnt[1] = 0;
    press_spin(1);
    mcred[1]--;
    check("b_start_busy",    {31'd0, busy_o[1]}, 32'd1);
    check("b_start_credits", {24'd0, cred_o[1]}, 32'd9);
    expect_spin(1, 0);
    repeat (3) @(negedge clk);
    press_spin(1);
    repeat (2) @(negedge clk);
    press_spin(1);
    check("b_mid_busy",    {31'd0, busy_o[1]}, 32'd1);
    check("b_mid_credits", {24'd0, cred_o[1]}, 32'd9);
    finish_spin(1);
    check("win_count_b", win_cnt[1], 32'd0);

    // Saturation: 240 coins to 250, then a win plus a coin in the SCORE cycle.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 240; i++) begin
      press_coin(0);
      @(negedge clk);
    end
    mcred[0] = 250;
    check("coins_250", {24'd0, cred_o[0]}, 32'd250);
    press_spin(0);
    mcred[0]--;
    check("sat_start_credits", {24'd0, cred_o[0]}, 32'd249);
    expect_spin(0, 1);
    n = 0;
    while (!(busy_o[0] === 1'b1 && mov_o[0] === 3'b000) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("score_seen", {29'd0, mov_o[0]}, 32'd0);
    coin_i[0] = 1'b1;
    finish_spin(0);
    coin_i[0] = 1'b0;

    // Reset in the middle of SPIN2.
    press_spin(0);
    mcred[0]--;
    check("rs_start_credits", {24'd0, cred_o[0]}, 32'd254);
    n = 0;
    while (mov_o[0] !== 3'b110 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("spin2_seen", {29'd0, mov_o[0]}, 32'd6);
    win_cnt[0] = 0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",    {31'd0, busy_o[0]}, 32'd0);
    check("mid_rst_reel0",   {29'd0, r0_o[0]},   32'd0);
    check("mid_rst_reel1",   {29'd0, r1_o[0]},   32'd0);
    check("mid_rst_reel2",   {29'd0, r2_o[0]},   32'd0);
    check("mid_rst_moving",  {29'd0, mov_o[0]},  32'd0);
    check("mid_rst_credits", {24'd0, cred_o[0]}, 32'd10);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("post_rst_busy",    {31'd0, busy_o[0]}, 32'd0);
    check("post_rst_credits", {24'd0, cred_o[0]}, 32'd10);
    check("post_rst_no_win",  win_cnt[0], 32'd0);

    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spin_ctrl.md
# spin_ctrl

Spin controller for the slot machine. It consumes the debounced spin and coin button levels, detects their rising edges, manages the credit balance, and runs the three reels through a spin/stop sequence. Each reel stops in turn, then the controller scores the result and pays out. It sits directly downstream of the button debouncers and upstream of the reel display/driver logic.

## Interface
- REEL_DIV, 1000000: clock cycles per reel tick (≥2)
- SPIN_TICKS, 20: base number of ticks reel 0 advances before stopping (≥1)
- STOP_GAP, 10: extra ticks between successive reel stops (≥1)
- RAND_EN, 1: 1 = add lfsr[2:0] (sampled at start) to SPIN_TICKS; 0 = deterministic length
- INIT_CREDITS, 10: credit value after reset (0–255)
- PAYOUT, 8: credits added on three-of-a-kind
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- db_spin  in  1  debounced spin button level
- db_coin  in  1  debounced coin button level
- reel0, reel1, reel2  out  3 each  current reel symbol (0–7)
- reel_moving  out  3  bit i = reel i advancing
- busy  out  1  high whenever state ≠ IDLE
- credits  out  8  credit balance
- win  out  1  one-cycle pulse on three-of-a-kind
- win_sym  out  3  symbol of the last win; holds until the next win

## Operation
- Edge detect: registered previous copies of db_spin and db_coin. Each resets to 1, so a button held through reset does not trigger. start_edge = db_spin & ~prev; coin_edge likewise.
- Tick generator: free-running counter 0..REEL_DIV-1. tick is a 1-cycle pulse when the counter equals REEL_DIV-1. The counter resets to 0.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Shifts every cycle, seed 16'hACE1.
- FSM states: IDLE, SPIN3, SPIN2, SPIN1, SCORE.
  - IDLE: a start is accepted when start_edge=1 and credits≠0. On acceptance, credits decrements, the state goes to SPIN3, reel_moving becomes 3'b111, and tick_left loads L = SPIN_TICKS + (RAND_EN ? lfsr[2:0] : 0).
  - If credits=0, or the state is not IDLE, start_edge is discarded and never queued.
  - SPIN3/SPIN2/SPIN1: on each tick, if tick_left≠0, every moving reel advances and tick_left decrements. If tick_left=0, the lowest-index moving reel stops instead (no reel advances on that tick), tick_left loads STOP_GAP, and the state steps SPIN3→SPIN2→SPIN1→SCORE.
  - Reel advance per tick (3-bit wrap): reel0 += 1, reel1 += 2, reel2 += 3.
  - Net effect: reel0 advances L ticks, reel1 advances L+STOP_GAP ticks, reel2 advances L+2·STOP_GAP ticks.
  - SCORE (one cycle): if reel0==reel1==reel2, win=1, win_sym=reel0, and credits += PAYOUT. Then return to IDLE.
- Credit arithmetic: 9-bit internal sum, saturates at 255, never below 0.
  - coin_edge adds 1 in any state.
  - Simultaneous events are summed in the same cycle: coin + accepted start gives net 0; coin + payout gives +PAYOUT+1, saturated.
- Reels hold their position between spins; the next spin starts from where they stopped.
- rst mid-spin: the FSM returns immediately to IDLE. Reels, credits, and all other registers return to their reset values. No payout or refund occurs.

## Timing
- Reset values: reel0/1/2=0, reel_moving=3'b000, busy=0, credits=INIT_CREDITS, win=0, win_sym=0, tick counter=0, lfsr=16'hACE1, state=IDLE.
- Start latency: db_spin first sampled high at cycle N → at N+1, busy=1, reel_moving=3'b111, and credits reflect the decrement.
- Reel updates and stops occur in the cycle after the tick pulse. reel_moving bit i falls in that same cycle.
- win is high for exactly the one cycle following SCORE, and busy falls in the same cycle. A start_edge in that cycle is accepted.
- Coin latency: credits update 1 cycle after db_coin first sampled high.

## Test plan
- Reset with db_spin held high, then held for 100 cycles → busy stays 0, credits=10. After release and press again → busy=1 one cycle later, credits=9.
- INIT_CREDITS=0; press spin → busy stays 0. Press coin → credits=1. Press spin → credits=0, spin runs.
- REEL_DIV=4, SPIN_TICKS=8, STOP_GAP=8, RAND_EN=0, from reset; press spin → all reels stop at 0, win pulses once, win_sym=0, credits=10-1+8=17.
- REEL_DIV=4, SPIN_TICKS=1, STOP_GAP=1, RAND_EN=0 → reels stop at 1,4,1; no win pulse; credits=9. Extra spin presses during the spin are ignored (credits stay 9).
- credits forced to 250 via 240 coin presses from INIT_CREDITS=10. Run the winning configuration above with a coin edge in the SCORE cycle → credits=255 (saturated).
- Assert rst while in SPIN2 → next cycle state=IDLE, reels=0, reel_moving=0, credits=INIT_CREDITS, win never pulses.
